// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipelined control decoder: opcodes, funcodes,
// control-word bit positions and the multdiv FSM state type.
package pipe_ctrl_pkg;

   localparam int CTRL_W_DEF = 20;

   localparam logic [4:0] OP_R    = 5'd0;
   localparam logic [4:0] OP_J    = 5'd1;
   localparam logic [4:0] OP_BNEI = 5'd2;
   localparam logic [4:0] OP_JAL  = 5'd3;
   localparam logic [4:0] OP_JR   = 5'd4;
   localparam logic [4:0] OP_ADDI = 5'd5;
   localparam logic [4:0] OP_BLTI = 5'd6;
   localparam logic [4:0] OP_SW   = 5'd7;
   localparam logic [4:0] OP_LW   = 5'd8;
   localparam logic [4:0] OP_SETX = 5'd21;
   localparam logic [4:0] OP_BEX  = 5'd22;

   localparam logic [4:0] FN_ADD = 5'd0;
   localparam logic [4:0] FN_SUB = 5'd1;
   localparam logic [4:0] FN_MUL = 5'd6;
   localparam logic [4:0] FN_DIV = 5'd7;

   localparam int B_RDST   = 0;
   localparam int B_RWE    = 1;
   localparam int B_BACKC  = 2;
   localparam int B_A0     = 3;
   localparam int B_A1     = 4;
   localparam int B_B0     = 5;
   localparam int B_B1     = 6;
   localparam int B_ALUINB = 7;
   localparam int B_T      = 8;
   localparam int B_BEXC   = 9;
   localparam int B_JALC   = 10;
   localparam int B_SWC    = 11;
   localparam int B_ISR    = 12;
   localparam int B_ISMD   = 13;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decoder producing the static control bits.
// isMD is only decoded when PIPE_CTRL_MD_EN is defined.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic [4:0]        opcode_i,
   input  logic [4:0]        funcode_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   logic is_r, is_bnei, is_jal, is_jr, is_addi, is_blti, is_sw, is_lw, is_setx, is_bex;

   assign is_r    = (opcode_i == OP_R);
   assign is_bnei = (opcode_i == OP_BNEI);
   assign is_jal  = (opcode_i == OP_JAL);
   assign is_jr   = (opcode_i == OP_JR);
   assign is_addi = (opcode_i == OP_ADDI);
   assign is_blti = (opcode_i == OP_BLTI);
   assign is_sw   = (opcode_i == OP_SW);
   assign is_lw   = (opcode_i == OP_LW);
   assign is_setx = (opcode_i == OP_SETX);
   assign is_bex  = (opcode_i == OP_BEX);

   always_comb begin
      // NOTE: default every bit first so no path through the block leaves a bit unassigned (no latch).
      ctrl_o           = '0;
      ctrl_o[B_RDST]   = is_sw | is_bnei | is_blti | is_jr;
      ctrl_o[B_RWE]    = is_r | is_addi | is_lw | is_jal | is_setx;
      ctrl_o[B_ALUINB] = is_sw | is_addi | is_lw;
      ctrl_o[B_JALC]   = is_jal;
      ctrl_o[B_BEXC]   = is_bex;
      ctrl_o[B_SWC]    = is_sw;
      ctrl_o[B_ISR]    = is_r;
      ctrl_o[B_B1]     = is_jal | is_setx;
      ctrl_o[B_B0]     = is_lw | is_setx;
`ifdef PIPE_CTRL_MD_EN
      ctrl_o[B_ISMD]   = is_r & ((funcode_i == FN_MUL) | (funcode_i == FN_DIV));
`endif
   end

`ifndef PIPE_CTRL_MD_EN
   logic unused_funcode;
   assign unused_funcode = ^funcode_i;
`endif

endmodule

// File: rtl/pipe_controller.sv
// Pipelined control decoder: decode in D, resolve dynamic bits in X, carry the
// word to W, squash on taken transfers. Multdiv stall logic under PIPE_CTRL_MD_EN.
module pipe_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     insn_valid,
   input  logic [4:0]               opcode,
   input  logic [4:0]               funcode,
   input  logic                     overflow,
   input  logic                     isLargerThan,
   input  logic                     isNotEqual,
   input  logic                     md_rdy,
   output logic [CTRL_W-1:0]        ctrl_x,
   output logic [STAGES*CTRL_W-1:0] ctrl_all,
   output logic [STAGES-1:0]        valid_all,
   output logic                     stall_fd,
   output logic                     flush,
   output logic                     md_start_mult,
   output logic                     md_start_div
);

   logic [CTRL_W-1:0] dec_word;
   logic [CTRL_W-1:0] ctrl_q [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [4:0]        x_op_q, x_fn_q;
   logic              x_hold, load_x;
   logic              x_r, x_arith_fn, ovf_ok, lt;

   ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
      .opcode_i  (opcode),
      .funcode_i (funcode),
      .ctrl_o    (dec_word)
   );

   // X keeps opcode/funcode because the static word alone cannot tell j from a no-op.
   assign x_r        = (x_op_q == OP_R);
   assign x_arith_fn = (x_fn_q == FN_ADD) | (x_fn_q == FN_SUB) | (x_fn_q == FN_MUL) | (x_fn_q == FN_DIV);
   assign ovf_ok     = overflow & ((x_op_q == OP_ADDI) | (x_r & x_arith_fn));
   assign lt         = ~isLargerThan & isNotEqual;

   always_comb begin
      ctrl_x = '0;
      if (valid_q[0]) begin
         ctrl_x          = ctrl_q[0];
         ctrl_x[B_BACKC] = ovf_ok;
         ctrl_x[B_T]     = (x_op_q == OP_SETX) | ovf_ok;
         ctrl_x[B_A1]    = (x_op_q == OP_J) | (x_op_q == OP_JAL) | (x_op_q == OP_JR)
                         | ((x_op_q == OP_BEX) & isNotEqual);
         ctrl_x[B_A0]    = (x_op_q == OP_JR) | ((x_op_q == OP_BLTI) & lt)
                         | ((x_op_q == OP_BNEI) & isNotEqual);
      end
   end

   // ctrl_x is already zero for a bubble, so no separate valid term is needed.
   assign flush  = ctrl_x[B_A0] | ctrl_x[B_A1];
   assign load_x = ~x_hold & insn_valid & ~stall_fd & ~flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the stage words are ordinary flops, not a RAM, so they are cleared with everything else.
         for (int k = 0; k < STAGES; k++) ctrl_q[k] <= '0;
         valid_q <= '0;
         x_op_q  <= '0;
         x_fn_q  <= '0;
      end else begin
         // NOTE: all state updates use non-blocking assignment so stage k reads the pre-edge value of stage k-1.
         if (!x_hold) begin
            valid_q[0] <= load_x;
            ctrl_q[0]  <= load_x ? dec_word : '0;
            x_op_q     <= load_x ? opcode : '0;
            x_fn_q     <= load_x ? funcode : '0;
            valid_q[1] <= valid_q[0];
            ctrl_q[1]  <= ctrl_x;
         end else begin
            valid_q[1] <= 1'b0;
            ctrl_q[1]  <= '0;
         end
         for (int k = 2; k < STAGES; k++) begin
            valid_q[k] <= valid_q[k-1];
            ctrl_q[k]  <= ctrl_q[k-1];
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_pack
      assign ctrl_all[k*CTRL_W +: CTRL_W] = ctrl_q[k];
   end
   assign valid_all = valid_q;

`ifdef PIPE_CTRL_MD_EN
   md_state_e state_q;
   logic      start_mult_q, start_div_q, x_is_md;

   assign x_is_md  = valid_q[0] & ctrl_q[0][B_ISMD];
   assign x_hold   = x_is_md & ~md_rdy;
   assign stall_fd = x_is_md | (state_q == MD_BUSY);

   // Start pulses are registered as the op enters X, which is always an IDLE cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= MD_IDLE;
         start_mult_q <= 1'b0;
         start_div_q  <= 1'b0;
      end else begin
         start_mult_q <= load_x & dec_word[B_ISMD] & (funcode == FN_MUL);
         start_div_q  <= load_x & dec_word[B_ISMD] & (funcode == FN_DIV);
         case (state_q)
            MD_IDLE: if (x_is_md && !md_rdy) state_q <= MD_BUSY;
            MD_BUSY: if (md_rdy) state_q <= MD_IDLE;
            default: state_q <= MD_IDLE;
         endcase
      end
   end

   assign md_start_mult = start_mult_q;
   assign md_start_div  = start_div_q;
`else
   logic unused_md_rdy;
   assign unused_md_rdy = md_rdy;
   assign x_hold        = 1'b0;
   assign stall_fd      = 1'b0;
   assign md_start_mult = 1'b0;
   assign md_start_div  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller; W-stage words are checked against a scoreboard queue.
module tb_pipe_controller;

   localparam int STAGES = 3;
   localparam int CW     = 20;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              insn_valid = 1'b0;
   logic [4:0]        opcode = '0;
   logic [4:0]        funcode = '0;
   logic              overflow = 1'b0;
   logic              isLargerThan = 1'b0;
   logic              isNotEqual = 1'b0;
   logic              md_rdy = 1'b0;
   logic [CW-1:0]        ctrl_x;
   logic [STAGES*CW-1:0] ctrl_all;
   logic [STAGES-1:0]    valid_all;
   logic              stall_fd, flush, md_start_mult, md_start_div;

   int n_pass  = 0;
   int n_total = 0;
   logic [CW-1:0] sb [$];

   pipe_controller #(.STAGES(STAGES), .CTRL_W(CW)) dut (
      .clock         (clock),
      .reset         (reset),
      .insn_valid    (insn_valid),
      .opcode        (opcode),
      .funcode       (funcode),
      .overflow      (overflow),
      .isLargerThan  (isLargerThan),
      .isNotEqual    (isNotEqual),
      .md_rdy        (md_rdy),
      .ctrl_x        (ctrl_x),
      .ctrl_all      (ctrl_all),
      .valid_all     (valid_all),
      .stall_fd      (stall_fd),
      .flush         (flush),
      .md_start_mult (md_start_mult),
      .md_start_div  (md_start_div)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] stage(input int k);
      return 32'(ctrl_all[k*CW +: CW]);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive D and X-stage inputs, check X results, record the finalised word, advance one edge.
   task automatic step(input string tag, input logic dv, input logic [4:0] op, input logic [4:0] fn,
                       input logic ovf, input logic gt, input logic ne,
                       input logic [CW-1:0] exp_x, input logic exp_fl, input logic x_valid);
      insn_valid   = dv;
      opcode       = op;
      funcode      = fn;
      overflow     = ovf;
      isLargerThan = gt;
      isNotEqual   = ne;
      #1;
      check({tag, ".ctrl_x"}, 32'(ctrl_x), 32'(exp_x));
      check({tag, ".flush"}, 32'(flush), 32'(exp_fl));
      if (x_valid) sb.push_back(exp_x);
      tick();
   endtask

   always @(negedge clock) begin
      if (!reset && valid_all[STAGES-1]) begin
         if (sb.size() == 0) check("W.unexpected", 32'(valid_all[STAGES-1]), 32'(0));
         else check("W.word", stage(STAGES-1), 32'(sb.pop_front()));
      end
   end

   initial begin
      #12;
      check("rst.valid", 32'(valid_all), 32'(0));
      check("rst.ctrl_all", 32'(|ctrl_all), 32'(0));
      check("rst.ctrl_x", 32'(ctrl_x), 32'(0));
      check("rst.stall", 32'(stall_fd), 32'(0));
      check("rst.flush", 32'(flush), 32'(0));
      check("rst.start", 32'({md_start_mult, md_start_div}), 32'(0));
      reset = 1'b0;
      tick();

      step("addi.in",   1, 5,  0, 0, 0, 0, 'h000, 0, 0);
      step("addi",      1, 2,  0, 1, 0, 0, 'h186, 0, 1);
      check("addi.M", stage(1), 'h186);
      check("bnei.Xstatic", stage(0), 'h001);
      step("bnei",      1, 8,  0, 0, 0, 1, 'h009, 1, 1);
      check("flush.valid", 32'(valid_all), 32'(3'b110));
      check("flush.Xword", stage(0), 'h000);
      step("bubble1",   1, 7,  0, 0, 0, 0, 'h000, 0, 0);
      step("sw",        1, 6,  0, 1, 0, 0, 'h881, 0, 1);
      step("blti_gt",   1, 6,  0, 0, 1, 1, 'h001, 0, 1);
      step("blti_lt",   1, 21, 0, 0, 0, 1, 'h009, 1, 1);
      step("bubble2",   1, 21, 0, 0, 0, 0, 'h000, 0, 0);
      step("setx",      1, 0,  0, 0, 0, 0, 'h162, 0, 1);
      step("r_add_ovf", 1, 9,  0, 1, 0, 0, 'h1106, 0, 1);
      step("op9",       1, 3,  0, 1, 1, 1, 'h000, 0, 1);
      step("jal",       0, 0,  0, 0, 0, 0, 'h452, 1, 1);
      step("bubble3",   1, 4,  0, 0, 0, 0, 'h000, 0, 0);
      step("jr",        1, 22, 0, 0, 0, 0, 'h019, 1, 1);
      step("bubble4",   1, 22, 0, 0, 0, 0, 'h000, 0, 0);
      step("bex",       1, 1,  0, 0, 0, 1, 'h210, 1, 1);
      step("bubble5",   1, 1,  0, 0, 0, 0, 'h000, 0, 0);
      step("j",         0, 0,  0, 0, 0, 0, 'h010, 1, 1);
      for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0, 0, 0, 'h000, 0, 0);

`ifdef PIPE_CTRL_MD_EN
      step("mul.in", 1, 0, 6, 0, 0, 0, 'h000, 0, 0);
      insn_valid = 1; opcode = 5; funcode = 0; overflow = 0; isNotEqual = 0; md_rdy = 0;
      #1;
      check("mul.start", 32'(md_start_mult), 32'(1));
      check("mul.start_div", 32'(md_start_div), 32'(0));
      check("mul.stall0", 32'(stall_fd), 32'(1));
      check("mul.ctrl_x", 32'(ctrl_x), 'h3002);
      tick();
      for (int i = 1; i < 5; i++) begin
         md_rdy = (i == 4);
         #1;
         check($sformatf("mul.stall%0d", i), 32'(stall_fd), 32'(1));
         check($sformatf("mul.nostart%0d", i), 32'(md_start_mult), 32'(0));
         check($sformatf("mul.bubbleM%0d", i), 32'(valid_all[1]), 32'(0));
         if (i == 4) sb.push_back('h3002);
         tick();
      end
      md_rdy = 0;
      check("mul.M", stage(1), 'h3002);
      check("mul.Xbubble", 32'(valid_all[0]), 32'(0));
      check("mul.release", 32'(stall_fd), 32'(0));
      step("mul.addi_in", 1, 5, 0, 0, 0, 0, 'h000, 0, 0);
      step("addi2",       1, 0, 7, 0, 0, 0, 'h082, 0, 1);

      insn_valid = 0; md_rdy = 1;
      #1;
      check("div.start", 32'(md_start_div), 32'(1));
      check("div.start_mult", 32'(md_start_mult), 32'(0));
      check("div.stall", 32'(stall_fd), 32'(1));
      check("div.ctrl_x", 32'(ctrl_x), 'h3002);
      sb.push_back('h3002);
      tick();
      md_rdy = 0;
      check("div.idle", 32'(stall_fd), 32'(0));
      check("div.valid", 32'(valid_all[1:0]), 32'(2'b10));
      step("div.addi_in", 1, 5, 0, 0, 0, 0, 'h000, 0, 0);
      step("addi3",       0, 0, 0, 0, 0, 0, 'h082, 0, 1);
      for (int i = 0; i < 3; i++) step("idle2", 0, 0, 0, 0, 0, 0, 'h000, 0, 0);

      step("mul2.in", 1, 0, 6, 0, 0, 0, 'h000, 0, 0);
      insn_valid = 0; md_rdy = 0;
      #1;
      check("mul2.start", 32'(md_start_mult), 32'(1));
      tick();
      check("mul2.busy_stall", 32'(stall_fd), 32'(1));
      reset = 1'b1;
      #1;
      check("rst2.stall", 32'(stall_fd), 32'(0));
      check("rst2.valid", 32'(valid_all), 32'(0));
      check("rst2.ctrl_all", 32'(|ctrl_all), 32'(0));
      check("rst2.ctrl_x", 32'(ctrl_x), 32'(0));
      check("rst2.start", 32'({md_start_mult, md_start_div}), 32'(0));
      reset = 1'b0;
      tick();
      md_rdy = 1;
      #1;
      check("stray_rdy.stall", 32'(stall_fd), 32'(0));
      check("stray_rdy.start", 32'({md_start_mult, md_start_div}), 32'(0));
      tick();
      md_rdy = 0;
      check("stray_rdy.after", 32'(stall_fd), 32'(0));
      step("post.in", 1, 5, 0, 0, 0, 0, 'h000, 0, 0);
      step("post",    0, 0, 0, 1, 0, 0, 'h186, 0, 1);
`else
      step("div.in", 1, 0, 7, 0, 0, 0, 'h000, 0, 0);
      insn_valid = 1; opcode = 0; funcode = 6; overflow = 0; md_rdy = 1;
      #1;
      check("div.nostall", 32'(stall_fd), 32'(0));
      check("div.nostart", 32'(md_start_div), 32'(0));
      check("div.nostart_mult", 32'(md_start_mult), 32'(0));
      check("div.ctrl_x", 32'(ctrl_x), 'h1002);
      sb.push_back('h1002);
      tick();
      insn_valid = 0; md_rdy = 0; overflow = 1;
      #1;
      check("mul.nostall", 32'(stall_fd), 32'(0));
      check("mul.nostart", 32'(md_start_mult), 32'(0));
      check("mul.ctrl_x", 32'(ctrl_x), 'h1106);
      sb.push_back('h1106);
      tick();
      overflow = 0;
      check("mul.M", stage(1), 'h1106);
`endif

      for (int i = 0; i < 4; i++) step("drain", 0, 0, 0, 0, 0, 0, 'h000, 0, 0);
      check("sb.empty", 32'(sb.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined successor to the single-cycle control decoder. Decodes the D-stage opcode/funcode into the 20-bit control word and carries it down a parametrised pipeline of STAGES registers (X, M, …, W). Resolves the condition-dependent bits (T, backC, A0, A1) in X, squashes younger instructions on taken control transfers, and stalls the front end around the multiply/divide unit.

## Interface
- STAGES, 3, pipeline registers after decode (X first, W last); legal ≥ 2
- CTRL_W, 20, control word width; legal ≥ 14; bits 14..CTRL_W-1 always 0
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- insn_valid  in  1  D-stage instruction present
- opcode  in  5  D-stage opcode
- funcode  in  5  D-stage ALU funcode
- overflow  in  1  ALU/multdiv overflow for the X-stage instruction
- isLargerThan  in  1  X-stage compare result, rd > rs
- isNotEqual  in  1  X-stage compare result, rd ≠ rs
- md_rdy  in  1  multdiv result ready, one-cycle pulse
- ctrl_x  out  CTRL_W  finalised control word of the X stage (combinational dynamic bits)
- ctrl_all  out  STAGES*CTRL_W  registered words, stage k at [k*CTRL_W +: CTRL_W]; slice 0 holds static bits only
- valid_all  out  STAGES  per-stage valid
- stall_fd  out  1  hold PC, F/D latch and D decode
- flush  out  1  squash F and D
- md_start_mult, md_start_div  out  1  one-cycle multdiv start

## Operation
- Bit map: 0 Rdst, 1 Rwe, 2 backC, 3 A0, 4 A1, 5 B0, 6 B1, 7 ALUinB, 8 T, 9 bexc, 10 jalc, 11 swc, 12 isR, 13 isMD.
- Opcodes: R 0, j 1, bnei 2, jal 3, jr 4, addi 5, blti 6, sw 7, lw 8, setx 21, bex 22; others decode to all-zero. Funcodes: add 0, sub 1, mul 6, div 7.
- Static bits (decoded in D): Rdst = sw|bnei|blti|jr; Rwe = R|addi|lw|jal|setx; ALUinB = sw|addi|lw; jalc = jal; bexc = bex; swc = sw; isR = R; B1 = jal|setx; B0 = lw|setx; isMD = R & (mul|div).
- Dynamic bits (X, from inputs): ovf_ok = overflow & (addi | R&(add|sub|mul|div)); backC = ovf_ok; T = setx | ovf_ok; A1 = j|jal|jr|(bex & isNotEqual); A0 = jr|(blti & lt)|(bnei & isNotEqual), lt = ~isLargerThan & isNotEqual.
- Invalid stage (bubble): entire word forced to 0.
- flush = valid X & (A0|A1). Next edge loads bubble into X; datapath squashes F.
- Multdiv FSM, states IDLE, BUSY:
  - IDLE → BUSY when valid X has isMD; md_start_mult or md_start_div asserted exactly in that cycle.
  - BUSY: X holds, stall_fd = 1, bubble enters M each cycle; md_start_* = 0.
  - BUSY → IDLE on md_rdy; X advances that edge with overflow sampled that cycle.
  - In IDLE with isMD in X, stall_fd = 1 too (X cannot leave until md_rdy).
- stall_fd and flush are mutually exclusive by construction (stalled X holds a non-branch).

## Timing
- Reset: all valid_all = 0, ctrl_all = 0, ctrl_x = 0, stall_fd = 0, flush = 0, md_start_* = 0, FSM IDLE. Reset mid-stall abandons the multdiv op; md_rdy while IDLE with no isMD in X is ignored.
- Unstalled instruction accepted at edge n appears in ctrl_x after n, in stage k after n+k.
- stall_fd = 1: D not captured; instruction in D must be held by upstream.
- Dynamic bits captured into stage 1 at the edge X advances; downstream stages never change them.
- Zero-latency md_rdy (in the start cycle) is legal: one-cycle op, no BUSY.

## Configuration
- PIPE_CTRL_MD_EN defined: multdiv FSM, stall and md_start_* as above.
- Undefined: mul/div decode as plain R-type; isMD = 0; md_start_* tied 0; stall_fd tied 0; md_rdy ignored.

## Structure
- Package pipe_ctrl_pkg: opcode/funcode localparams, control-bit index constants, CTRL_W default, FSM state enum.
- Sub-module ctrl_decode: purely combinational static-bit decoder (opcode, funcode → CTRL_W), instantiated once in D.

## Test plan
- addi (5) in D, overflow=1 in X → ctrl_x bits Rwe, ALUinB, T, backC = 1; 0x0186 in stage 1; reaches W after 3 edges.
- bnei (2), isNotEqual=1 in X → A0=1, flush=1 one cycle; next X valid=0, word 0.
- blti (6), isLargerThan=1, isNotEqual=1 → A0=0, flush=0; same with isLargerThan=0 → A0=1.
- mul (R, funcode 6), md_rdy 5 cycles after start → md_start_mult one pulse, stall_fd high 5 cycles, 4 bubbles into M, X advances on md_rdy.
- reset asserted during BUSY → all outputs 0 immediately; later md_rdy ignored.
- Opcode 9 → all-zero word; without PIPE_CTRL_MD_EN, div passes with no stall, md_start_div = 0.
